// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with condition-flag update and a sticky halt.
// Stall holds all state. Flush or an empty slot inserts a bubble. Once halted, later loads are discarded.
module ex_mem_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [3:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [15:0] ex_store_data,
    output logic        mem_valid,
    output logic        mem_reg_write,
    output logic        mem_mem_read,
    output logic        mem_mem_write,
    output logic [15:0] mem_result,
    output logic [15:0] mem_store_data,
    output logic [3:0]  mem_rd,
    output logic [3:0]  mem_opcode,
    output logic [2:0]  flags,
    output logic        halted
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic       do_load;
    logic       do_bubble;
    logic [2:0] flags_next;
    logic       zero_res;

    // A load attempted while halted turns into a bubble, the same as an empty slot.
    assign do_load   = ex_valid & ~stall & ~flush & ~halted;
    assign do_bubble = flush | (~stall & ~do_load);
    assign zero_res  = (ex_result == 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_result     <= 16'h0000;
            mem_store_data <= 16'h0000;
            mem_rd         <= 4'h0;
            mem_opcode     <= 4'h0;
        end else if (do_load) begin
            mem_valid      <= 1'b1;
            mem_reg_write  <= ex_reg_write;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_opcode     <= ex_opcode;
        end else if (do_bubble) begin
            mem_valid      <= 1'b0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
        end
    end

    // Flags are {Z,V,N}. Shifts and XOR refresh only Z, and overflow matters only for ADD/SUB.
    always_comb begin
        flags_next = flags;
        if (do_load) begin
            case (ex_opcode)
                OP_ADD, OP_SUB:                 flags_next = {zero_res, ex_ovfl, ex_result[15]};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_next = {zero_res, flags[1:0]};
                default:                        flags_next = flags;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags  <= 3'b000;
            halted <= 1'b0;
        end else begin
            flags <= flags_next;
            if (do_load && ex_opcode == OP_HLT) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Directed testbench for ex_mem_pipe with hand-computed expected values.
module tb_ex_mem_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, ex_valid;
    logic [3:0]  ex_opcode, ex_rd;
    logic [15:0] ex_result, ex_store_data;
    logic        ex_ovfl, ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
    logic [15:0] mem_result, mem_store_data;
    logic [3:0]  mem_rd, mem_opcode;
    logic [2:0]  flags;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    ex_mem_pipe dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data),
        .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_opcode(mem_opcode), .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    // Drives one execute-stage instruction with its control bits, then samples 1 ns after the next rising edge.
    task automatic applyStimulus(input logic st, input logic fl, input logic v,
                                 input logic [3:0] op, input logic [15:0] res,
                                 input logic ov, input logic [3:0] rd,
                                 input logic rw, input logic mr, input logic mw,
                                 input logic [15:0] sd);
        stall = st; flush = fl; ex_valid = v; ex_opcode = op; ex_result = res;
        ex_ovfl = ov; ex_rd = rd; ex_reg_write = rw; ex_mem_read = mr;
        ex_mem_write = mw; ex_store_data = sd;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        stall = 0; flush = 0; ex_valid = 0; ex_opcode = 0; ex_result = 0; ex_ovfl = 0;
        ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0; ex_store_data = 0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_valid",  {15'd0, mem_valid}, 16'h0000);
        checkOutput("rst_result", mem_result, 16'h0000);
        checkOutput("rst_flags",  {13'd0, flags}, 16'h0000);
        checkOutput("rst_halted", {15'd0, halted}, 16'h0000);
        #5 rst_n = 1'b1;

        // ADD with a zero result and overflow set
        applyStimulus(0, 0, 1, 4'h0, 16'h0000, 1, 4'd3, 1, 0, 0, 16'h0000);
        checkOutput("add_valid", {15'd0, mem_valid}, 16'h0001);
        checkOutput("add_rd",    {12'd0, mem_rd}, 16'h0003);
        checkOutput("add_rw",    {15'd0, mem_reg_write}, 16'h0001);
        checkOutput("add_flags", {13'd0, flags}, 16'h0006);

        applyStimulus(0, 0, 1, 4'h1, 16'h8001, 0, 4'd5, 1, 0, 0, 16'h0000);
        checkOutput("sub_flags",  {13'd0, flags}, 16'h0001);
        checkOutput("sub_result", mem_result, 16'h8001);

        applyStimulus(0, 0, 1, 4'h4, 16'h0000, 1, 4'd5, 1, 0, 0, 16'h0000);
        checkOutput("sll_flags", {13'd0, flags}, 16'h0005);

        applyStimulus(0, 0, 1, 4'h2, 16'h1234, 1, 4'd6, 1, 0, 0, 16'h0000);
        checkOutput("xor_flags", {13'd0, flags}, 16'h0001);

        // LW with overflow set: flags must not move
        applyStimulus(0, 0, 1, 4'h8, 16'h0040, 1, 4'd7, 1, 1, 0, 16'h0000);
        checkOutput("lw_flags",  {13'd0, flags}, 16'h0001);
        checkOutput("lw_mr",     {15'd0, mem_mem_read}, 16'h0001);
        checkOutput("lw_opcode", {12'd0, mem_opcode}, 16'h0008);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, 4'h0, 16'h0000, 1, 4'd9, 1, 0, 1, 16'h7777);
            checkOutput("stall_result", mem_result, 16'h0040);
            checkOutput("stall_rd",     {12'd0, mem_rd}, 16'h0007);
            checkOutput("stall_valid",  {15'd0, mem_valid}, 16'h0001);
            checkOutput("stall_mw",     {15'd0, mem_mem_write}, 16'h0000);
            checkOutput("stall_flags",  {13'd0, flags}, 16'h0001);
        end

        applyStimulus(0, 0, 0, 4'h0, 16'h5555, 0, 4'd2, 1, 1, 1, 16'h0000);
        checkOutput("idle_valid",  {15'd0, mem_valid}, 16'h0000);
        checkOutput("idle_ctrl",   {13'd0, mem_reg_write, mem_mem_read, mem_mem_write}, 16'h0000);
        checkOutput("idle_result", mem_result, 16'h0040);

        applyStimulus(0, 0, 1, 4'h9, 16'h0100, 0, 4'd0, 0, 0, 1, 16'hBEEF);
        checkOutput("sw_mw",   {15'd0, mem_mem_write}, 16'h0001);
        checkOutput("sw_data", mem_store_data, 16'hBEEF);

        // Flush beats stall
        applyStimulus(1, 1, 1, 4'h9, 16'h0200, 0, 4'd0, 0, 0, 1, 16'h1111);
        checkOutput("flush_valid",  {15'd0, mem_valid}, 16'h0000);
        checkOutput("flush_mw",     {15'd0, mem_mem_write}, 16'h0000);
        checkOutput("flush_result", mem_result, 16'h0100);
        checkOutput("flush_data",   mem_store_data, 16'hBEEF);
        checkOutput("flush_flags",  {13'd0, flags}, 16'h0001);

        applyStimulus(0, 1, 1, 4'hF, 16'h0000, 0, 4'd0, 0, 0, 0, 16'h0000);
        checkOutput("hlt_flush_halted", {15'd0, halted}, 16'h0000);
        applyStimulus(1, 0, 1, 4'hF, 16'h0000, 0, 4'd0, 0, 0, 0, 16'h0000);
        checkOutput("hlt_stall_halted", {15'd0, halted}, 16'h0000);
        checkOutput("hlt_stall_valid",  {15'd0, mem_valid}, 16'h0000);

        applyStimulus(0, 0, 1, 4'hF, 16'h0000, 0, 4'd0, 0, 0, 0, 16'h0000);
        checkOutput("hlt_halted", {15'd0, halted}, 16'h0001);
        checkOutput("hlt_valid",  {15'd0, mem_valid}, 16'h0001);
        checkOutput("hlt_opcode", {12'd0, mem_opcode}, 16'h000F);

        applyStimulus(0, 0, 1, 4'h0, 16'h0000, 1, 4'd4, 1, 0, 0, 16'h0000);
        checkOutput("post_hlt_halted", {15'd0, halted}, 16'h0001);
        checkOutput("post_hlt_valid",  {15'd0, mem_valid}, 16'h0000);
        checkOutput("post_hlt_flags",  {13'd0, flags}, 16'h0001);
        checkOutput("post_hlt_rd",     {12'd0, mem_rd}, 16'h0000);

        // Reset clears halted
        rst_n = 1'b0;
        #1;
        checkOutput("rst2_halted", {15'd0, halted}, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 4'h0, 16'hFFFE, 0, 4'd1, 1, 0, 0, 16'h0000);
        checkOutput("add2_valid", {15'd0, mem_valid}, 16'h0001);
        checkOutput("add2_flags", {13'd0, flags}, 16'h0001);

        // Reset pulse between edges while stalled
        stall = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid",  {15'd0, mem_valid}, 16'h0000);
        checkOutput("mid_rst_result", mem_result, 16'h0000);
        checkOutput("mid_rst_rw",     {15'd0, mem_reg_write}, 16'h0000);
        checkOutput("mid_rst_flags",  {13'd0, flags}, 16'h0000);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 4'h1, 16'h0007, 0, 4'd2, 1, 0, 0, 16'h0000);
        checkOutput("after_rst_valid",  {15'd0, mem_valid}, 16'h0001);
        checkOutput("after_rst_result", mem_result, 16'h0007);
        checkOutput("after_rst_flags",  {13'd0, flags}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
